// File: rtl/ysyx_23060236_icache_if.sv
// Fetch-side and refill-side bundles for the instruction cache.
// The fetch bundle faces the IFU and the read bundle faces the crossbar.
interface ysyx_23060236_icache_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [31:0] resp_inst;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_err
  );
  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

interface ysyx_23060236_axi_rd_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [1:0]  arburst;
  logic [3:0]  arlen;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, arburst, arlen, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  araddr, arvalid, arburst, arlen, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ysyx_23060236_icache.sv
// Direct-mapped instruction cache with whole-line INCR burst refill
// and a fence_i that invalidates every line once the FSM is idle.
module ysyx_23060236_icache #(
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic fence_i,
  ysyx_23060236_icache_if.slave  fetch,
  ysyx_23060236_axi_rd_if.master ifu
);
  localparam int WB       = OFFSET_BITS - 2;
  localparam int WORDS    = 1 << WB;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, AR, R, RESP
  } state_t;

  state_t state, state_n;

  logic [31:2]          addr_q;
  logic [INDEX_BITS-1:0] idx;
  logic [WB-1:0]        word;
  logic [TAG_BITS-1:0]  tag;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][WORDS];

  logic [WB-1:0] cnt_q;
  logic          err_q;
  logic          fence_pend;
  logic [31:0]   inst_q;
  logic          rerr_q;

  logic req_fire, beat, hit, beat_err, line_err, fence_now;

  assign idx  = addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign word = addr_q[OFFSET_BITS-1:2];
  assign tag  = addr_q[31:OFFSET_BITS+INDEX_BITS];

  assign req_fire = fetch.req_valid & fetch.req_ready;
  assign beat     = ifu.rvalid & ifu.rready;
  assign hit      = valid_q[idx] & (tag_q[idx] == tag);
  assign beat_err = ifu.rresp != 2'b00;
  assign line_err = err_q | beat_err;

  // A pending fence always wins the idle slot because req_ready is held low.
  assign fence_now = (state == IDLE)
                   & ((fence_i & ~req_fire) | fence_pend);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (req_fire) state_n = LOOKUP;
      LOOKUP: state_n = hit ? RESP : AR;
      AR:     if (ifu.arready) state_n = R;
      R:      if (beat && ifu.rlast) state_n = RESP;
      RESP:   if (fetch.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fetch.req_ready  = (state == IDLE) & ~fence_pend;
    fetch.resp_valid = state == RESP;
    fetch.resp_inst  = inst_q;
    fetch.resp_err   = rerr_q;
    ifu.arvalid      = state == AR;
    ifu.araddr       = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    ifu.arburst      = 2'b01;
    ifu.arlen        = 4'(WORDS - 1);
    ifu.rready       = state == R;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      inst_q     <= '0;
      rerr_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      fence_pend <= 1'b0;
      valid_q    <= '0;
    end else begin
      if (req_fire) addr_q <= fetch.req_addr[31:2];
      if (state == LOOKUP && hit) begin
        inst_q <= data_q[idx][word];
        rerr_q <= 1'b0;
      end
      if (state == AR && ifu.arready) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (beat) begin
        if (cnt_q == word) inst_q <= ifu.rdata;
        err_q <= line_err;
        cnt_q <= cnt_q + 1'b1;
        if (ifu.rlast) begin
          rerr_q       <= line_err;
          valid_q[idx] <= ~line_err;
        end
      end
      if (fence_now) begin
        valid_q    <= '0;
        fence_pend <= 1'b0;
      end else if (fence_i) begin
        fence_pend <= 1'b1;
      end
    end
  end

  // Line storage carries no reset; valid bits guard it.
  always_ff @(posedge clock) begin
    if (beat) begin
      data_q[idx][cnt_q] <= ifu.rdata;
      if (ifu.rlast) tag_q[idx] <= tag;
    end
  end
endmodule

// File: tb/tb_ysyx_23060236_icache.sv
// Directed bench for the instruction cache: misses, hits, conflicts,
// error beats, fences, backpressure and reset during a refill.
module tb_ysyx_23060236_icache;
  logic clock;
  logic reset;
  logic fence_i;

  ysyx_23060236_icache_if fe ();
  ysyx_23060236_axi_rd_if ax ();

  ysyx_23060236_icache #(
    .OFFSET_BITS(4),
    .INDEX_BITS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fence_i(fence_i),
    .fetch(fe.slave),
    .ifu(ax.master)
  );

  int checks;
  int failures;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, output bit ok);
    int n;
    n = 0;
    fe.req_valid = 1'b1;
    fe.req_addr  = a;
    while (fe.req_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    ok = fe.req_ready === 1'b1;
    step();
    fe.req_valid = 1'b0;
  endtask

  task automatic serve_refill(
    input  logic [31:0] d0,
    input  int          err_beat,
    input  int          fence_beat,
    output logic [31:0] seen_addr,
    output logic [3:0]  seen_len,
    output logic [1:0]  seen_burst,
    output bit          ok
  );
    int n;
    n = 0;
    while (ax.arvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ok         = ax.arvalid === 1'b1;
    seen_addr  = ax.araddr;
    seen_len   = ax.arlen;
    seen_burst = ax.arburst;
    if (!ok) return;
    ax.arready = 1'b1;
    step();
    ax.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ax.rvalid = 1'b1;
      ax.rdata  = d0 + 32'(i);
      ax.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      ax.rlast  = i == 3;
      fence_i   = i == fence_beat;
      step();
    end
    ax.rvalid = 1'b0;
    ax.rlast  = 1'b0;
    ax.rresp  = 2'b00;
    fence_i   = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    int n;
    n = 0;
    while (fe.resp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ok = fe.resp_valid === 1'b1;
  endtask

  task automatic ack_resp();
    fe.resp_ready = 1'b1;
    step();
    fe.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (fe.req_ready !== 1'b1 || fe.resp_valid !== 1'b0 ||
        fe.resp_err !== 1'b0 || fe.resp_inst !== 32'h0) begin
      failures++;
      $display("FAIL reset_fetch rdy=%b vld=%b err=%b inst=%h want 1 0 0 0",
               fe.req_ready, fe.resp_valid, fe.resp_err, fe.resp_inst);
    end
    checks++;
    if (ax.arvalid !== 1'b0 || ax.rready !== 1'b0 ||
        ax.araddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus arvalid=%b rready=%b araddr=%h want 0 0 0",
               ax.arvalid, ax.rready, ax.araddr);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    bit ok;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    do_req(32'h3000_0008, ok);
    serve_refill(32'hA0, -1, -1, a, l, b, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cold_ar no AR seen, want AR");
    end
    checks++;
    if (a !== 32'h3000_0000 || l !== 4'd3 || b !== 2'b01) begin
      failures++;
      $display("FAIL cold_ar_fields addr=%h len=%0d burst=%0d want 30000000 3 1",
               a, l, b);
    end
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'hA2 || fe.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL cold_resp vld=%b inst=%h err=%b want 1 a2 0",
               ok, fe.resp_inst, fe.resp_err);
    end
    ack_resp();
  endtask

  task automatic test_hit();
    bit ok;
    do_req(32'h3000_000C, ok);
    checks++;
    if (fe.resp_valid !== 1'b0 || ax.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL hit_lookup vld=%b arvalid=%b want 0 0",
               fe.resp_valid, ax.arvalid);
    end
    step();
    checks++;
    if (fe.resp_valid !== 1'b1 || ax.arvalid !== 1'b0 ||
        fe.resp_inst !== 32'hA3 || fe.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL hit_resp vld=%b arvalid=%b inst=%h err=%b want 1 0 a3 0",
               fe.resp_valid, ax.arvalid, fe.resp_inst, fe.resp_err);
    end
    ack_resp();
  endtask

  task automatic test_conflict();
    bit ok;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    do_req(32'h3000_0108, ok);
    serve_refill(32'hB0, -1, -1, a, l, b, ok);
    checks++;
    if (!ok || a !== 32'h3000_0100) begin
      failures++;
      $display("FAIL conflict_ar seen=%b addr=%h want 1 30000100", ok, a);
    end
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'hB2) begin
      failures++;
      $display("FAIL conflict_resp vld=%b inst=%h want 1 b2", ok, fe.resp_inst);
    end
    ack_resp();
    do_req(32'h3000_0008, ok);
    serve_refill(32'hC0, -1, -1, a, l, b, ok);
    checks++;
    if (!ok || a !== 32'h3000_0000) begin
      failures++;
      $display("FAIL conflict_remiss seen=%b addr=%h want 1 30000000", ok, a);
    end
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'hC2) begin
      failures++;
      $display("FAIL conflict_resp2 vld=%b inst=%h want 1 c2", ok, fe.resp_inst);
    end
    ack_resp();
  endtask

  task automatic test_error_beat();
    bit ok;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    do_req(32'h3000_0048, ok);
    serve_refill(32'hD0, 1, -1, a, l, b, ok);
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'hD2 || fe.resp_err !== 1'b1) begin
      failures++;
      $display("FAIL err_resp vld=%b inst=%h err=%b want 1 d2 1",
               ok, fe.resp_inst, fe.resp_err);
    end
    ack_resp();
    do_req(32'h3000_0048, ok);
    serve_refill(32'hE0, -1, -1, a, l, b, ok);
    checks++;
    if (!ok || a !== 32'h3000_0040) begin
      failures++;
      $display("FAIL err_rerefill seen=%b addr=%h want 1 30000040", ok, a);
    end
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'hE2 || fe.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clean vld=%b inst=%h err=%b want 1 e2 0",
               ok, fe.resp_inst, fe.resp_err);
    end
    ack_resp();
  endtask

  task automatic test_fence_mid_refill();
    bit ok;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    do_req(32'h3000_0084, ok);
    serve_refill(32'hF0, -1, 1, a, l, b, ok);
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'hF1 || fe.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL fence_resp vld=%b inst=%h err=%b want 1 f1 0",
               ok, fe.resp_inst, fe.resp_err);
    end
    ack_resp();
    checks++;
    if (fe.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL fence_pend_ready rdy=%b want 0", fe.req_ready);
    end
    do_req(32'h3000_0084, ok);
    serve_refill(32'h50, -1, -1, a, l, b, ok);
    checks++;
    if (!ok || a !== 32'h3000_0080) begin
      failures++;
      $display("FAIL fence_remiss seen=%b addr=%h want 1 30000080", ok, a);
    end
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'h51) begin
      failures++;
      $display("FAIL fence_refill vld=%b inst=%h want 1 51", ok, fe.resp_inst);
    end
    ack_resp();
  endtask

  task automatic test_fence_with_req();
    bit ok;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    fence_i      = 1'b1;
    fe.req_valid = 1'b1;
    fe.req_addr  = 32'h3000_0084;
    step();
    fence_i      = 1'b0;
    fe.req_valid = 1'b0;
    step();
    checks++;
    if (fe.resp_valid !== 1'b1 || fe.resp_inst !== 32'h51) begin
      failures++;
      $display("FAIL fence_req_hit vld=%b inst=%h want 1 51",
               fe.resp_valid, fe.resp_inst);
    end
    ack_resp();
    do_req(32'h3000_0084, ok);
    serve_refill(32'h60, -1, -1, a, l, b, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fence_req_miss no AR seen, want AR");
    end
    wait_resp(ok);
    ack_resp();
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    do_req(32'h3000_00C8, ok);
    n = 0;
    while (ax.arvalid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ax.arvalid !== 1'b1 || ax.araddr !== 32'h3000_00C0) begin
        failures++;
        $display("FAIL bp_ar%0d arvalid=%b addr=%h want 1 300000c0",
                 i, ax.arvalid, ax.araddr);
      end
      step();
    end
    serve_refill(32'h70, -1, -1, a, l, b, ok);
    wait_resp(ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fe.resp_valid !== 1'b1 || fe.resp_inst !== 32'h72 ||
          fe.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_resp%0d vld=%b inst=%h rdy=%b want 1 72 0",
                 i, fe.resp_valid, fe.resp_inst, fe.req_ready);
      end
      step();
    end
    ack_resp();
  endtask

  task automatic test_back_to_back();
    fe.resp_ready = 1'b1;
    fe.req_valid  = 1'b1;
    fe.req_addr   = 32'h3000_00C0;
    step();
    step();
    checks++;
    if (fe.resp_valid !== 1'b1 || fe.resp_inst !== 32'h70) begin
      failures++;
      $display("FAIL b2b_first vld=%b inst=%h want 1 70",
               fe.resp_valid, fe.resp_inst);
    end
    fe.req_addr = 32'h3000_00C4;
    step();
    step();
    step();
    checks++;
    if (fe.resp_valid !== 1'b1 || fe.resp_inst !== 32'h71) begin
      failures++;
      $display("FAIL b2b_second vld=%b inst=%h want 1 71",
               fe.resp_valid, fe.resp_inst);
    end
    fe.req_valid = 1'b0;
    step();
    fe.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    bit ok;
    int n;
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    do_req(32'h3000_0300, ok);
    n = 0;
    while (ax.arvalid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ax.arvalid !== 1'b0 || ax.rready !== 1'b0 || fe.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid arvalid=%b rready=%b rdy=%b want 0 0 1",
               ax.arvalid, ax.rready, fe.req_ready);
    end
    step();
    reset = 1'b0;
    step();
    do_req(32'h3000_000C, ok);
    serve_refill(32'h90, -1, -1, a, l, b, ok);
    checks++;
    if (!ok || a !== 32'h3000_0000) begin
      failures++;
      $display("FAIL rst_invalid seen=%b addr=%h want 1 30000000", ok, a);
    end
    wait_resp(ok);
    checks++;
    if (!ok || fe.resp_inst !== 32'h93) begin
      failures++;
      $display("FAIL rst_refill vld=%b inst=%h want 1 93", ok, fe.resp_inst);
    end
    ack_resp();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    fence_i       = 1'b0;
    fe.req_valid  = 1'b0;
    fe.req_addr   = 32'h0;
    fe.resp_ready = 1'b0;
    ax.arready    = 1'b0;
    ax.rdata      = 32'h0;
    ax.rresp      = 2'b00;
    ax.rlast      = 1'b0;
    ax.rvalid     = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_error_beat();
    test_fence_mid_refill();
    test_fence_with_req();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_refill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
